// File: rtl/multi_channel_request_fifo.sv
// Per-channel request FIFOs behind one write port, drained by a round-robin
// arbiter into a single registered valid/ready output stage.
module multi_channel_request_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_CH     = 4,
    parameter int AFULL_TH   = 12,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int PW        = DEPTH_LOG2 + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_valid,
    input  logic [CH_W-1:0]        i_wr_ch,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,
    output logic                   o_wr_ready,
    output logic                   o_rd_valid,
    output logic [CH_W-1:0]        o_rd_ch,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    input  logic                   i_rd_ready,
    input  logic [NUM_CH-1:0]      i_flush,
    output logic [NUM_CH*PW-1:0]   o_count,
    output logic [NUM_CH-1:0]      o_empty,
    output logic [NUM_CH-1:0]      o_full,
    output logic [NUM_CH-1:0]      o_afull,
    output logic                   o_wr_drop
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [NUM_CH][DEPTH];
    logic [PW-1:0]         wr_ptr [NUM_CH];
    logic [PW-1:0]         rd_ptr [NUM_CH];
    logic [PW-1:0]         count  [NUM_CH];
    logic [CH_W-1:0]       rr_ptr;

    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     wr_acc;
    logic [NUM_CH-1:0]     pop_vec;
    logic                  out_free;
    logic                  grant_vld;
    logic [CH_W-1:0]       grant_ch;
    logic [CH_W-1:0]       cand;
    logic [DATA_WIDTH-1:0] head;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_status
        assign o_count[c*PW +: PW] = count[c];
        assign o_empty[c]          = (count[c] == '0);
        assign o_full[c]           = (count[c] == PW'(DEPTH));
        assign o_afull[c]          = (count[c] >= PW'(AFULL_TH));
        assign eligible[c]         = (count[c] != '0) && !i_flush[c];
    end

    assign o_wr_ready = !o_full[i_wr_ch] && !i_flush[i_wr_ch];
    assign out_free   = !o_rd_valid || i_rd_ready || (i_flush[o_rd_ch] && o_rd_valid);

    always_comb begin
        wr_acc = '0;
        if (i_wr_valid && o_wr_ready) begin
            wr_acc[i_wr_ch] = 1'b1;
        end
    end

    // Search starts one past the last grant; i == NUM_CH wraps back to rr_ptr itself.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = rr_ptr + CH_W'(i);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
    end

    always_comb begin
        pop_vec = '0;
        if (grant_vld && out_free) begin
            pop_vec[grant_ch] = 1'b1;
        end
    end

    assign head = mem[grant_ch][rd_ptr[grant_ch][DEPTH_LOG2-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_wr_valid && o_wr_ready) begin
            mem[i_wr_ch][wr_ptr[i_wr_ch][DEPTH_LOG2-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (i_flush[c]) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                    count[c]  <= '0;
                end else begin
                    if (wr_acc[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
                    if (pop_vec[c]) rd_ptr[c] <= rd_ptr[c] + PW'(1);
                    if (wr_acc[c] && !pop_vec[c]) begin
                        count[c] <= count[c] + PW'(1);
                    end else if (!wr_acc[c] && pop_vec[c]) begin
                        count[c] <= count[c] - PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rd_valid <= 1'b0;
            o_rd_ch    <= '0;
            o_rd_data  <= '0;
            o_wr_drop  <= 1'b0;
            rr_ptr     <= CH_W'(NUM_CH - 1);
        end else begin
            o_wr_drop <= i_wr_valid && !o_wr_ready;
            if (out_free) begin
                if (grant_vld) begin
                    o_rd_valid <= 1'b1;
                    o_rd_ch    <= grant_ch;
                    o_rd_data  <= head;
                    rr_ptr     <= grant_ch;
                end else begin
                    o_rd_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_request_fifo.sv
// Bench for multi_channel_request_fifo: directed tables and sequences plus a
// randomized run compared cycle by cycle against a queue-based reference model.
module tb_multi_channel_request_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [31:0] wr_data = '0;
    logic        rd_ready = 1'b0;
    logic [3:0]  flush = '0;
    logic        wr_ready, rd_valid, wr_drop;
    logic [1:0]  rd_ch;
    logic [31:0] rd_data;
    logic [19:0] count;
    logic [3:0]  empty, full, afull;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_channel_request_fifo dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .i_wr_ch(wr_ch),
        .i_wr_data(wr_data), .o_wr_ready(wr_ready), .o_rd_valid(rd_valid),
        .o_rd_ch(rd_ch), .o_rd_data(rd_data), .i_rd_ready(rd_ready),
        .i_flush(flush), .o_count(count), .o_empty(empty), .o_full(full),
        .o_afull(afull), .o_wr_drop(wr_drop)
    );

    // Reference model: one queue per channel plus the output stage contents.
    logic [31:0] mq [4][$];
    logic        mv;
    logic [1:0]  mch;
    logic [31:0] md;
    logic [1:0]  mrr;
    logic        mdrop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic m_ready(input logic [1:0] ch, input logic [3:0] fl);
        return (mq[ch].size() < 16) && !fl[ch];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) mq[c].delete();
        mv = 1'b0; mch = '0; md = '0; mrr = 2'd3; mdrop = 1'b0;
    endtask

    task automatic model_step(input logic wv, input logic [1:0] wch, input logic [31:0] wd,
                              input logic rdy, input logic [3:0] fl);
        logic acc, free, found;
        logic [1:0] g;
        int idx;
        acc   = wv && m_ready(wch, fl);
        mdrop = wv && !m_ready(wch, fl);
        free  = !mv || rdy || fl[mch];
        found = 1'b0;
        g     = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = (int'(mrr) + i) % 4;
            if (!found && mq[idx].size() > 0 && !fl[idx]) begin
                found = 1'b1;
                g = 2'(idx);
            end
        end
        if (free) begin
            if (found) begin
                md = mq[g].pop_front();
                mv = 1'b1; mch = g; mrr = g;
            end else begin
                mv = 1'b0;
            end
        end
        for (int c = 0; c < 4; c++) if (fl[c]) mq[c].delete();
        if (acc) mq[wch].push_back(wd);
    endtask

    task automatic compare_model();
        chk("rd_valid", rd_valid, mv);
        chk("rd_ch", rd_ch, mch);
        chk("rd_data", rd_data, md);
        chk("wr_drop", wr_drop, mdrop);
        for (int c = 0; c < 4; c++) begin
            chk("count", count[c*5 +: 5], mq[c].size());
            chk("empty", empty[c], mq[c].size() == 0);
            chk("full", full[c], mq[c].size() == 16);
            chk("afull", afull[c], mq[c].size() >= 12);
        end
    endtask

    // One clock: drive inputs, check write-ready, advance model and DUT, compare.
    task automatic cycle(input logic wv, input logic [1:0] wch, input logic [31:0] wd,
                         input logic rdy, input logic [3:0] fl);
        wr_valid = wv; wr_ch = wch; wr_data = wd; rd_ready = rdy; flush = fl;
        #1;
        if (rst_n) begin
            chk("wr_ready", wr_ready, m_ready(wch, fl));
            model_step(wv, wch, wd, rdy, fl);
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(0, 0, 0, 0, 4'b0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        wv;
        logic [1:0]  wch;
        logic [31:0] wd;
        logic        rdy;
        logic        ev;
        logic [1:0]  ech;
        logic [31:0] ed;
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic [1:0] wch, input logic [31:0] wd,
                                input logic rdy, input logic ev, input logic [1:0] ech,
                                input logic [31:0] ed);
        vec_t v;
        v.wv = wv; v.wch = wch; v.wd = wd; v.rdy = rdy;
        v.ev = ev; v.ech = ech; v.ed = ed;
        return v;
    endfunction

    vec_t vt [15];

    initial begin
        // Round-robin order then single-write latency, one row per clock.
        vt[0]  = mk(1, 0, 32'hA0,   0, 0, 0, 0);
        vt[1]  = mk(1, 0, 32'hA1,   0, 1, 0, 32'hA0);
        vt[2]  = mk(1, 1, 32'hB0,   0, 1, 0, 32'hA0);
        vt[3]  = mk(1, 3, 32'hD0,   0, 1, 0, 32'hA0);
        vt[4]  = mk(1, 3, 32'hD1,   0, 1, 0, 32'hA0);
        vt[5]  = mk(0, 0, 0,        1, 1, 1, 32'hB0);
        vt[6]  = mk(0, 0, 0,        1, 1, 3, 32'hD0);
        vt[7]  = mk(0, 0, 0,        1, 1, 0, 32'hA1);
        vt[8]  = mk(0, 0, 0,        1, 1, 3, 32'hD1);
        vt[9]  = mk(0, 0, 0,        1, 0, 0, 0);
        vt[10] = mk(0, 0, 0,        1, 0, 0, 0);
        vt[11] = mk(0, 0, 0,        1, 0, 0, 0);
        vt[12] = mk(1, 1, 32'hCAFE, 1, 0, 0, 0);
        vt[13] = mk(0, 0, 0,        1, 1, 1, 32'hCAFE);
        vt[14] = mk(0, 0, 0,        1, 0, 0, 0);

        @(posedge clk);
        #1;

        // Reset state.
        do_reset();
        cycle(0, 0, 0, 0, 4'b0);
        chk("rst_empty", empty, 4'hF);
        chk("rst_full", full, 4'h0);
        chk("rst_valid", rd_valid, 1'b0);
        for (int c = 0; c < 4; c++) begin
            wr_ch = 2'(c);
            #1;
            chk("rst_wr_ready", wr_ready, 1'b1);
        end

        // Fill ch2 with the output stalled.
        for (int k = 0; k < 16; k++) begin
            cycle(1, 2, 32'h100 + k, 0, 4'b0);
            if (k == 11) chk("fill_afull_11", afull[2], 1'b0);
            if (k == 12) chk("fill_afull_12", afull[2], 1'b1);
        end
        chk("fill_count15", count[14:10], 5'd15);
        chk("fill_out", rd_data, 32'h100);
        cycle(1, 2, 32'h110, 0, 4'b0);
        chk("fill_count16", count[14:10], 5'd16);
        chk("fill_full", full[2], 1'b1);
        wr_valid = 1'b1; wr_ch = 2'd2; wr_data = 32'h111;
        #1;
        chk("fill_ready_low", wr_ready, 1'b0);
        cycle(1, 2, 32'h111, 0, 4'b0);
        chk("fill_drop", wr_drop, 1'b1);
        cycle(0, 0, 0, 0, 4'b0);
        chk("fill_drop_clear", wr_drop, 1'b0);
        for (int k = 0; k < 17; k++) begin
            chk("drain_valid", rd_valid, 1'b1);
            chk("drain_data", rd_data, 32'h100 + k);
            cycle(0, 0, 0, 1, 4'b0);
        end
        chk("drain_done", rd_valid, 1'b0);
        chk("drain_count", count[14:10], 5'd0);

        // Table-driven round-robin and latency.
        do_reset();
        for (int r = 0; r < 15; r++) begin
            cycle(vt[r].wv, vt[r].wch, vt[r].wd, vt[r].rdy, 4'b0);
            chk("tbl_valid", rd_valid, vt[r].ev);
            if (vt[r].ev) begin
                chk("tbl_ch", rd_ch, vt[r].ech);
                chk("tbl_data", rd_data, vt[r].ed);
            end
        end

        // Flush of the channel held in the stalled output stage.
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1, 3, 32'h300 + k, 0, 4'b0);
        chk("flush_pre_ch", rd_ch, 2'd3);
        chk("flush_pre_count", count[19:15], 5'd4);
        wr_valid = 1'b1; wr_ch = 2'd3; wr_data = 32'h3FF; flush = 4'b1000;
        #1;
        chk("flush_ready_low", wr_ready, 1'b0);
        cycle(1, 3, 32'h3FF, 0, 4'b1000);
        chk("flush_count", count[19:15], 5'd0);
        chk("flush_valid", rd_valid, 1'b0);
        chk("flush_drop", wr_drop, 1'b1);
        chk("flush_others", count[14:0], 15'd0);
        cycle(1, 3, 32'h3AB, 0, 4'b0);
        cycle(0, 0, 0, 0, 4'b0);
        chk("flush_reuse", rd_data, 32'h3AB);

        // Wrap: 40 entries through ch0 with random consumer readiness.
        do_reset();
        begin
            int sent, got;
            logic r, wv, rdy_pre;
            sent = 0; got = 0;
            for (int n = 0; n < 600 && got < 40; n++) begin
                r = 1'($urandom_range(0, 1));
                wv = (sent < 40);
                rdy_pre = m_ready(2'd0, 4'b0);
                if (rd_valid && r) begin
                    chk("wrap_order", rd_data, 32'h5000 + got);
                    got++;
                end
                cycle(wv, 0, 32'h5000 + sent, r, 4'b0);
                if (wv && rdy_pre) sent++;
                chk("wrap_le16", count[4:0] <= 5'd16, 1'b1);
            end
            chk("wrap_done", got, 40);
        end

        // Reset in the middle of operation.
        do_reset();
        for (int k = 0; k < 32; k++) cycle(1, 2'(k % 4), 32'h700 + k, 0, 4'b0);
        chk("midrst_pre_valid", rd_valid, 1'b1);
        rst_n = 1'b0;
        cycle(1, 2, 32'h7FF, 1, 4'b0);
        rst_n = 1'b1;
        chk("midrst_valid", rd_valid, 1'b0);
        chk("midrst_data", rd_data, 32'h0);
        chk("midrst_ch", rd_ch, 2'd0);
        chk("midrst_count", count, 20'd0);
        chk("midrst_empty", empty, 4'hF);
        chk("midrst_afull", afull, 4'h0);
        chk("midrst_drop", wr_drop, 1'b0);
        cycle(1, 0, 32'hAA, 0, 4'b0);
        cycle(0, 0, 0, 0, 4'b0);
        chk("midrst_grant_ch", rd_ch, 2'd0);
        chk("midrst_grant_data", rd_data, 32'hAA);

        // Randomized run against the model, with one reset partway through.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] fl;
            logic rdy;
            fl = '0;
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 39) == 0) fl[c] = 1'b1;
            rdy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (n == 1000) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom, rdy, fl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
